// File: rtl/kcpsmx_ieu.sv
// kcpsmx_ieu: instruction encode/load unit.
// Packs decoded instruction field bundles into 18-bit instruction words and
// writes them sequentially into code memory through a registered write port.
// Optional build macro: KCPSMX_IEU_CHECKSUM_EN adds an XOR checksum output
// covering every word written during a session.
module kcpsmx_ieu #(
    parameter int CODE_DEPTH  = 10,
    parameter int INSTR_WIDTH = 18,
    parameter int FIELD_WIDTH = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [CODE_DEPTH-1:0]  base_addr_i,
    input  logic [CODE_DEPTH:0]    length_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [FIELD_WIDTH-1:0] in_format_i,
    input  logic [4:0]             in_operation_i,
    input  logic                   in_sel_i,
    input  logic [3:0]             in_x_i,
    input  logic [3:0]             in_y_i,
    input  logic [7:0]             in_constant_i,
    input  logic                   in_shift_dir_i,
    input  logic                   in_shift_const_i,
    input  logic [1:0]             in_shift_op_i,
    input  logic [1:0]             in_flags_i,
    input  logic [CODE_DEPTH-1:0]  in_code_addr_i,
    input  logic [5:0]             in_scratch_i,
    input  logic                   in_int_en_i,
    output logic                   code_we_o,
    output logic [CODE_DEPTH-1:0]  code_addr_o,
    output logic [INSTR_WIDTH-1:0] code_data_o,
    output logic                   busy_o,
    output logic                   done_o,
`ifdef KCPSMX_IEU_CHECKSUM_EN
    output logic [INSTR_WIDTH-1:0] checksum_o,
`endif
    output logic                   format_error_o
);

    localparam logic [FIELD_WIDTH-1:0] FMT_REG_REG   = 3'd0;
    localparam logic [FIELD_WIDTH-1:0] FMT_REG_CONST = 3'd1;
    localparam logic [FIELD_WIDTH-1:0] FMT_SHIFT     = 3'd2;
    localparam logic [FIELD_WIDTH-1:0] FMT_JUMP      = 3'd3;
    localparam logic [FIELD_WIDTH-1:0] FMT_PORT      = 3'd4;
    localparam logic [FIELD_WIDTH-1:0] FMT_SCRATCH   = 3'd5;
    localparam logic [FIELD_WIDTH-1:0] FMT_INTERRUPT = 3'd6;
    localparam logic [FIELD_WIDTH-1:0] FMT_RESERVED  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CODE_DEPTH:0]      count_q;
    logic [CODE_DEPTH:0]      len_q;
    logic [CODE_DEPTH-1:0]    base_q;
    logic                     code_we_q;
    logic [CODE_DEPTH-1:0]    code_addr_q;
    logic [INSTR_WIDTH-1:0]   code_data_q;
    logic                     format_error_q;
    logic [INSTR_WIDTH-1:0]   enc_w;
    logic                     in_ready_w;
    logic                     accept_w;
    logic                     session_start_w;
`ifdef KCPSMX_IEU_CHECKSUM_EN
    logic [INSTR_WIDTH-1:0]   checksum_q;
`endif

    // Abort wins over a simultaneous handshake: the bundle is dropped.
    assign accept_w        = in_valid_i && in_ready_w && !abort_i;
    assign session_start_w = (state_q == S_IDLE) && start_i && !abort_i;

    // Field packing: opcode and selector are common, unlisted bits stay 0.
    always_comb begin
        enc_w        = '0;
        enc_w[17:13] = in_operation_i;
        enc_w[12]    = in_sel_i;
        case (in_format_i)
            FMT_REG_REG: begin
                enc_w[11:8] = in_x_i;
                enc_w[7:4]  = in_y_i;
            end
            FMT_REG_CONST, FMT_PORT: begin
                enc_w[11:8] = in_x_i;
                enc_w[7:0]  = in_constant_i;
            end
            FMT_SHIFT: begin
                enc_w[11:8] = in_x_i;
                enc_w[3]    = in_shift_dir_i;
                enc_w[2:1]  = in_shift_op_i;
                enc_w[0]    = in_shift_const_i;
            end
            FMT_JUMP: begin
                enc_w[11:10]           = in_flags_i;
                enc_w[CODE_DEPTH-1:0]  = in_code_addr_i;
            end
            FMT_SCRATCH: begin
                enc_w[11:8] = in_x_i;
                enc_w[5:0]  = in_scratch_i;
            end
            FMT_INTERRUPT: begin
                enc_w[0] = in_int_en_i;
            end
            default: begin
                enc_w = enc_w;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; LOAD exits one cycle after the last accept so DONE
    // follows the final write strobe.
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = (length_i == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (count_q == len_q) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy_o     = (state_q == S_LOAD);
        done_o     = (state_q == S_DONE);
        in_ready_w = (state_q == S_LOAD) && (count_q < len_q);
    end

    // Session registers and the registered code memory write port.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q        <= '0;
            len_q          <= '0;
            base_q         <= '0;
            code_we_q      <= 1'b0;
            code_addr_q    <= '0;
            code_data_q    <= '0;
            format_error_q <= 1'b0;
`ifdef KCPSMX_IEU_CHECKSUM_EN
            checksum_q     <= '0;
`endif
        end else begin
            code_we_q <= 1'b0;
            if (session_start_w) begin
`ifdef KCPSMX_IEU_CHECKSUM_EN
                checksum_q <= '0;
`endif
                if (length_i != '0) begin
                    base_q         <= base_addr_i;
                    len_q          <= length_i;
                    count_q        <= '0;
                    format_error_q <= 1'b0;
                end
            end
            if (accept_w) begin
                if (in_format_i == FMT_RESERVED) begin
                    format_error_q <= 1'b1;
                end else begin
                    code_we_q   <= 1'b1;
                    code_addr_q <= base_q + count_q[CODE_DEPTH-1:0];
                    code_data_q <= enc_w;
                    count_q     <= count_q + 1'b1;
`ifdef KCPSMX_IEU_CHECKSUM_EN
                    checksum_q  <= checksum_q ^ enc_w;
`endif
                end
            end
        end
    end

    assign in_ready_o     = in_ready_w;
    assign code_we_o      = code_we_q;
    assign code_addr_o    = code_addr_q;
    assign code_data_o    = code_data_q;
    assign format_error_o = format_error_q;
`ifdef KCPSMX_IEU_CHECKSUM_EN
    assign checksum_o     = checksum_q;
`endif

endmodule
